// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shared multiplier controller
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int MULT_W          = 8;
    localparam int MULT_CYCLES     = 8;
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mult8.sv
// rtl/mult8.sv - 8-bit shift-add multiplier, done level 8 edges after the start edge
module mult8 (
    input  logic       clk,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       done,
    output logic [7:0] product
);

    logic [7:0] sa;
    logic [7:0] sb;
    logic [2:0] cnt;
    logic       run;

    // no reset: a start pulse reloads everything and clears a stale done
    always_ff @(posedge clk) begin
        if (start) begin
            sa      <= a;
            sb      <= b;
            product <= '0;
            cnt     <= '0;
            run     <= 1'b1;
            done    <= 1'b0;
        end else if (run) begin
            if (sb[0]) begin
                product <= product + sa;
            end
            sa  <= sa << 1;
            sb  <= sb >> 1;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // first requesting index at or after ptr, wrapping past N-1 back to 0
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin sharing of one mult8 with watchdog abort
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [MULT_W*N_REQ-1:0]  req_a,
    input  logic [MULT_W*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [MULT_W-1:0]        rsp_product,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     mult_start,
    output logic [MULT_W-1:0]        mult_a,
    output logic [MULT_W-1:0]        mult_b,
    input  logic                     mult_done,
    input  logic [MULT_W-1:0]        mult_product
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  ptr;
    logic [WW-1:0]  wdog;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]  arb_idx;
    logic           arb_any;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state; mult_done is only trusted in WAIT, the multiplier may hold a stale done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mult_done || (wdog == WD_LAST)) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state-decoded outputs; the grant is only exposed while idle
    always_comb begin
        req_ready  = (state == IDLE) ? arb_grant : '0;
        mult_start = (state == ISSUE);
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    // operand capture, watchdog, result capture and round-robin pointer advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            wdog        <= '0;
            mult_a      <= '0;
            mult_b      <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        mult_a <= req_a[int'(arb_idx)*MULT_W +: MULT_W];
                        mult_b <= req_b[int'(arb_idx)*MULT_W +: MULT_W];
                        rsp_id <= arb_idx;
                    end
                end
                ISSUE: begin
                    wdog <= '0;
                end
                WAIT: begin
                    if (mult_done) begin
                        rsp_product <= mult_product;
                        rsp_err     <= 1'b0;
                    end else if (wdog == WD_LAST) begin
                        rsp_product <= '0;
                        rsp_err     <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr <= (rsp_id == IW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
